// File: rtl/seq_pkg.sv
//==============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the sequence-detector path
//               (serializer front end now, seq_det later).
//               Contents:
//                 ser_state_t         - serializer FSM state encoding
//                 SEQ_WORD_W_DEFAULT  - default parallel word width
//                 SEQ_CNT_W           - width of the completed-word counter
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_SHIFT  = 2'd1,
        SER_PARITY = 2'd2
    } ser_state_t;

    localparam int SEQ_WORD_W_DEFAULT = 8;
    localparam int SEQ_CNT_W          = 16;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_serializer.sv
//==============================================================================
// Module      : seq_serializer
// Description : Parallel-to-serial front end for seq_det. Accepts WIDTH-bit
//               words over valid/ready and emits them MSB-first, one bit per
//               clk, with no idle gap between back-to-back words.
//               Optional build macro: SEQ_SER_PARITY_EN appends one even-parity
//               bit after each word (WIDTH+1 valid cycles per word).
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               in_data    - word to serialize, sampled on accept
//               in_valid   - upstream has a word
//               in_ready   - block can accept (forced low while rst=1)
//               data       - registered serial bit
//               data_valid - registered, data carries a word/parity bit
//               busy       - FSM not idle
//               words_sent - completed-word count, wraps at 16 bits
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = SEQ_WORD_W_DEFAULT,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 data,
    output logic                 data_valid,
    output logic                 busy,
    output logic [SEQ_CNT_W-1:0] words_sent
);

    localparam int c_CNT_W = $clog2(WIDTH);

    ser_state_t            r_state;
    // The current bit lives in r_data; r_sreg holds only the bits still to
    // come, so the shift register is one bit narrower than the word.
    logic [WIDTH-2:0]      r_sreg;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_data;
    logic                  r_data_valid;
    logic [SEQ_CNT_W-1:0]  r_words;
`ifdef SEQ_SER_PARITY_EN
    logic                  r_par;
`endif

    logic w_last;    // final cycle of a word: completes it and may chain the next
    logic w_accept;

`ifdef SEQ_SER_PARITY_EN
    assign w_last = (r_state == SER_PARITY);
`else
    assign w_last = (r_state == SER_SHIFT) && (r_cnt == '0);
`endif

    assign in_ready = !rst && ((r_state == SER_IDLE) || w_last);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SER_IDLE;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_data       <= IDLE_BIT;
            r_data_valid <= 1'b0;
            r_words      <= '0;
`ifdef SEQ_SER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else if ((r_state == SER_IDLE) || w_last) begin
            if (w_last) begin
                r_words <= r_words + 1'b1;
            end
            if (w_accept) begin
                // Load a new word; its MSB goes straight to the output so it
                // appears the cycle after the accept edge.
                r_state      <= SER_SHIFT;
                r_sreg       <= in_data[WIDTH-2:0];
                r_cnt        <= c_CNT_W'(WIDTH - 1);
                r_data       <= in_data[WIDTH-1];
                r_data_valid <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
                r_par        <= ^in_data;
`endif
            end else begin
                r_state      <= SER_IDLE;
                r_data       <= IDLE_BIT;
                r_data_valid <= 1'b0;
            end
        end else if ((r_state == SER_SHIFT) && (r_cnt != '0)) begin
            r_sreg       <= r_sreg << 1;
            r_cnt        <= r_cnt - 1'b1;
            r_data       <= r_sreg[WIDTH-2];
            r_data_valid <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
        end else if (r_state == SER_SHIFT) begin
            // Last data bit done: one extra cycle carrying even parity.
            r_state      <= SER_PARITY;
            r_data       <= r_par;
            r_data_valid <= 1'b1;
`endif
        end else begin
            // Unreachable encodings recover to idle.
            r_state      <= SER_IDLE;
            r_data       <= IDLE_BIT;
            r_data_valid <= 1'b0;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign busy       = (r_state != SER_IDLE);
    assign words_sent = r_words;

endmodule : seq_serializer

`default_nettype wire

// File: tb/tb_seq_serializer.sv
//==============================================================================
// Module      : tb_seq_serializer
// Description : Self-checking bench for seq_serializer (WIDTH=8, IDLE_BIT=0).
//               Expected bits are queued when a word is accepted and compared
//               as data_valid cycles appear. Honours SEQ_SER_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_serializer;

    localparam int c_W = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam int c_WPB = c_W + 1;   // valid cycles per word
`else
    localparam int c_WPB = c_W;
`endif

    logic           clk;
    logic           rst;
    logic [c_W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic           data;
    logic           data_valid;
    logic           busy;
    logic [15:0]    words_sent;

    seq_serializer #(.WIDTH(c_W), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    int idx      = 0;
    int dv_cnt   = 0;
    int dv_runs  = 0;
    bit prev_dv  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard producer: an accept at this edge queues the word's bits.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            for (int i = c_W - 1; i >= 0; i--) exp_q.push_back(in_data[i]);
`ifdef SEQ_SER_PARITY_EN
            exp_q.push_back(^in_data);
`endif
        end
    end

    // Scoreboard consumer and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_rst", {31'd0, in_ready}, 32'd0);
            idx = 0;
        end else if (data_valid) begin
            if (exp_q.size() == 0) chk("unexpected_bit", 32'd1, 32'd0);
            else                   chk("data_bit", {31'd0, data}, {31'd0, exp_q.pop_front()});
            chk("ready_in_word", {31'd0, in_ready}, (idx == c_WPB - 1) ? 32'd1 : 32'd0);
            chk("busy_in_word", {31'd0, busy}, 32'd1);
            idx = (idx == c_WPB - 1) ? 0 : idx + 1;
            dv_cnt++;
            if (!prev_dv) dv_runs++;
        end else begin
            chk("idle_data", {31'd0, data}, 32'd0);
            idx = 0;
        end
        prev_dv = data_valid;
    end

    // Called just after a posedge: present w and return just after its accept edge.
    task automatic drive_word(input logic [c_W-1:0] w);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_valid();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        dv_cnt  = 0;
        dv_runs = 0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data",       {31'd0, data}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_words",      {16'd0, words_sent}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 1: single word, first bit the cycle after accept
        clear_stats();
        drive_word(8'b1101_0110);
        stop_valid();
        @(negedge clk);
        chk("t1_first_bit_latency", {31'd0, data_valid}, 32'd1);
        @(posedge clk); #1;
        wait_idle();
        chk("t1_valid_cycles", dv_cnt, c_WPB);
        chk("t1_runs",         dv_runs, 32'd1);
        chk("t1_words",        {16'd0, words_sent}, 32'd1);
        chk("t1_idle_valid",   {31'd0, data_valid}, 32'd0);

        // 2: held valid, back-to-back words
        clear_stats();
        drive_word(8'hA5);
        drive_word(8'h3C);
        stop_valid();
        wait_idle();
        chk("t2_valid_cycles", dv_cnt, 2 * c_WPB);
        chk("t2_runs",         dv_runs, 32'd1);
        chk("t2_words",        {16'd0, words_sent}, 32'd3);

        // 3: reset after 3 bits discards the word
        drive_word(8'hFF);
        stop_valid();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t3_ready_in_rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("t3_valid_after_rst", {31'd0, data_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t3_ready_after", {31'd0, in_ready}, 32'd1);
        chk("t3_words",       {16'd0, words_sent}, 32'd0);
        chk("t3_valid_after", {31'd0, data_valid}, 32'd0);
        @(posedge clk); #1;

        // 4: valid held through reset, accepted on the first edge after release
        clear_stats();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_release", {31'd0, in_ready}, 32'd1);
        chk("t4_no_early_bit",  {31'd0, data_valid}, 32'd0);
        @(posedge clk); #1;
        stop_valid();
        @(negedge clk);
        chk("t4_first_bit", {31'd0, data_valid}, 32'd1);
        @(posedge clk); #1;
        wait_idle();
        chk("t4_valid_cycles", dv_cnt, c_WPB);
        chk("t4_words",        {16'd0, words_sent}, 32'd1);

        // 5: words_sent wrap
        force dut.r_words = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_words;
        @(negedge clk);
        chk("t5_preload", {16'd0, words_sent}, 32'h0000_FFFF);
        @(posedge clk); #1;
        drive_word(8'h5A);
        stop_valid();
        wait_idle();
        chk("t5_wrap", {16'd0, words_sent}, 32'd0);

        // 6: B0 then 03 back-to-back (parity bits 1 and 0 when enabled)
        clear_stats();
        drive_word(8'hB0);
        drive_word(8'h03);
        stop_valid();
        wait_idle();
        chk("t6_valid_cycles", dv_cnt, 2 * c_WPB);
        chk("t6_runs",         dv_runs, 32'd1);
        chk("t6_words",        {16'd0, words_sent}, 32'd2);
        chk("t6_queue_empty",  exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_serializer

`default_nettype wire
